// File: rtl/pix_sync_align.sv
// pix_sync_align
//   Brings an arcade core's sync/blank signals into the clk_sys domain, aligned
//   to its pixel-clock strobe.
//   - Generates a one-cycle pixel enable (ce_vid) from rising edges of pix_in.
//   - Delays each channel by a runtime-selected number of pixel edges, so that
//     blanking lines up with delayed pixel data.
//   - A watchdog forces FORCE_VAL onto sig_out while the core has stopped
//     pixel-clocking.
//
// Optional feature (macro PIX_MEASURE_EN):
//   Measures active width/height from the delayed ch0 (hblank) and ch1 (vblank)
//   taps. When the macro is undefined, meas_w/meas_h/meas_valid are tied to 0.
//
// Ports:
//   clk_sys     system clock, rising edge
//   reset_n     asynchronous active-low reset
//   pix_in      pixel-clock level, already synchronous to clk_sys
//   sig_in      raw sync/blank signals (ch0 hblank, ch1 vblank, ch2 hsync, ch3 vsync)
//   delay_sel   per-channel delay, channel c in [c*DW +: DW]
//   ce_vid      one-cycle pixel enable
//   sig_out     delayed or forced signals
//   stalled     watchdog flag
//   meas_w      active pixels per line
//   meas_h      active lines per frame
//   meas_valid  a complete frame has been measured (sticky)
module pix_sync_align #(
    parameter int                  CHANNELS  = 4,
    parameter int                  MAX_DELAY = 16,
    parameter int                  DW        = 4,
    parameter int                  TIMEOUT   = 1024,
    parameter logic [CHANNELS-1:0] FORCE_VAL = 4'b0011,
    parameter int                  CNT_W     = 10
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   pix_in,
    input  logic [CHANNELS-1:0]    sig_in,
    input  logic [CHANNELS*DW-1:0] delay_sel,
    output logic                   ce_vid,
    output logic [CHANNELS-1:0]    sig_out,
    output logic                   stalled,
    output logic [CNT_W-1:0]       meas_w,
    output logic [CNT_W-1:0]       meas_h,
    output logic                   meas_valid
);

    localparam int             WD_W   = $clog2(TIMEOUT + 1);
    localparam int             IW     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    logic                 pix_q;
    logic                 ce_vid_q;
    logic                 stalled_q;
    logic                 stalled_d;
    logic [WD_W-1:0]      wd_q;
    logic [WD_W-1:0]      wd_d;
    logic [MAX_DELAY-1:0] sr_q [CHANNELS];
    logic [MAX_DELAY-1:0] sr_d [CHANNELS];
    logic                 edge_s;
    logic [CHANNELS-1:0]  tap_s;

    // Edge detect, watchdog next state and shift-register next state
    always_comb begin
        edge_s = pix_in & ~pix_q;
        if (edge_s) begin
            wd_d = '0;
        end else if (wd_q == WD_MAX) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end
        // An edge in the cycle the counter would reach TIMEOUT clears it first,
        // so the stall flag never rises in that case.
        stalled_d = (wd_d == WD_MAX);
        for (int c = 0; c < CHANNELS; c++) begin
            if (edge_s) begin
                sr_d[c] = {sr_q[c][MAX_DELAY-2:0], sig_in[c]};
            end else begin
                sr_d[c] = sr_q[c];
            end
        end
    end

    // Core state: edge history, pixel enable, watchdog and delay lines
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pix_q     <= 1'b0;
            ce_vid_q  <= 1'b0;
            stalled_q <= 1'b0;
            wd_q      <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                sr_q[c] <= {MAX_DELAY{FORCE_VAL[c]}};
            end
        end else begin
            pix_q     <= pix_in;
            ce_vid_q  <= edge_s;
            stalled_q <= stalled_d;
            wd_q      <= wd_d;
            for (int c = 0; c < CHANNELS; c++) begin
                sr_q[c] <= sr_d[c];
            end
        end
    end

    // Tap select: delay_sel goes straight into the mux, clamped to the deepest tap
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(delay_sel[c*DW +: DW]) > MAX_DELAY - 1) begin
                tap_s[c] = sr_q[c][MAX_DELAY-1];
            end else begin
                tap_s[c] = sr_q[c][IW'(delay_sel[c*DW +: DW])];
            end
        end
    end

    assign ce_vid  = ce_vid_q;
    assign stalled = stalled_q;
    assign sig_out = stalled_q ? FORCE_VAL : tap_s;

`ifdef PIX_MEASURE_EN
    logic             hb_prev_q;
    logic             vb_prev_q;
    logic [CNT_W-1:0] w_cnt_q;
    logic [CNT_W-1:0] w_last_q;
    logic [CNT_W-1:0] line_q;
    logic [CNT_W-1:0] meas_w_q;
    logic [CNT_W-1:0] meas_h_q;
    logic             valid_q;
    logic             meas_ce_s;
    logic             hb_rise_s;
    logic             vb_rise_s;

    // Measure on the cycle the taps have just advanced, frozen while stalled
    assign meas_ce_s = ce_vid_q & ~stalled_q;
    assign hb_rise_s = tap_s[0] & ~hb_prev_q;
    assign vb_rise_s = tap_s[1] & ~vb_prev_q;

    // Width, line and frame-latch counters
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            // History starts at the reset tap level so the first pixel
            // cannot look like a blanking rise.
            hb_prev_q <= FORCE_VAL[0];
            vb_prev_q <= FORCE_VAL[1];
            w_cnt_q   <= '0;
            w_last_q  <= '0;
            line_q    <= '0;
            meas_w_q  <= '0;
            meas_h_q  <= '0;
            valid_q   <= 1'b0;
        end else if (meas_ce_s) begin
            hb_prev_q <= tap_s[0];
            vb_prev_q <= tap_s[1];
            if (hb_rise_s) begin
                w_last_q <= w_cnt_q;
                w_cnt_q  <= '0;
            end else if (!tap_s[0] && (w_cnt_q != '1)) begin
                w_cnt_q <= w_cnt_q + CNT_W'(1);
            end else begin
                w_cnt_q <= w_cnt_q;
            end
            if (vb_rise_s) begin
                meas_w_q <= w_last_q;
                meas_h_q <= line_q;
                line_q   <= '0;
                valid_q  <= 1'b1;
            end else if (hb_rise_s && !tap_s[1] && (line_q != '1)) begin
                line_q <= line_q + CNT_W'(1);
            end else begin
                line_q <= line_q;
            end
        end else begin
            hb_prev_q <= hb_prev_q;
        end
    end

    assign meas_w     = meas_w_q;
    assign meas_h     = meas_h_q;
    assign meas_valid = valid_q;
`else
    assign meas_w     = '0;
    assign meas_h     = '0;
    assign meas_valid = 1'b0;
`endif

endmodule
